mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//   Main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through
//   FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath mux selects, register and
//   memory enables, and aluop into alucontrol (00 add, 01 sub, 10 funct-decoded).
//   It stalls on a single-port memory ready handshake. It sits between the instruction
//   register and the datapath.
// PARAMETERS
//   MEM_TIMEOUT   default 16   max cycles waiting on mem_ready before bus_err; 0 disables
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   opcode       in   6   IR[31:26]; sampled in DECODE
//   zero         in   1   ALU zero flag; used in BRANCH
//   mem_ready    in   1   memory completes current read/write this cycle
//   pcwrite      out  1   unconditional PC load
//   pcwritecond  out  1   PC load qualified by zero (beq)
//   iord         out  1   memory address: 0 = PC, 1 = ALUOut
//   memread      out  1   memory read request
//   memwrite     out  1   memory write request
//   irwrite      out  1   load instruction register
//   memtoreg     out  1   regfile write data: 0 = ALUOut, 1 = MDR
//   regdst       out  1   write register: 0 = rt, 1 = rd
//   regwrite     out  1   regfile write enable
//   alusrca      out  1   ALU A: 0 = PC, 1 = reg A
//   alusrcb      out  2   ALU B: 00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//   pcsource     out  2   PC next: 00 ALU result, 01 ALUOut, 10 jump target
//   aluop        out  2   to alucontrol
//   illegal_op   out  1   one-cycle pulse: opcode unsupported, instruction dropped
//   bus_err      out  1   one-cycle pulse: memory wait exceeded MEM_TIMEOUT
//   state        out  4   current state encoding (debug)
// BEHAVIOUR
//   States (enc): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7,
//     BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Outputs are decoded from state; unlisted outputs are 0.
//   Reset: state <= FETCH immediately, wait counter <= 0, illegal_op/bus_err <= 0.
//   FETCH:  memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00;
//           irwrite=pcwrite=mem_ready (Mealy-gated). Stay until mem_ready, then go to DECODE.
//   DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target -> ALUOut). Next state by opcode:
//           000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP;
//           001000 -> ADDIEX; other -> FETCH with illegal_op pulsed on the transition.
//   MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD (lw) or MEMWR (sw), from the
//           opcode registered in DECODE.
//   MEMRD:  memread=1, iord=1; wait for mem_ready, then MEMWB.
//   MEMWB:  regwrite=1, memtoreg=1, regdst=0, then FETCH.
//   MEMWR:  memwrite=1, iord=1; wait for mem_ready, then FETCH.
//   EXEC:   alusrca=1, alusrcb=00, aluop=10, then ALUWB.
//   ALUWB:  regwrite=1, regdst=1, memtoreg=0, then FETCH.
//   BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, then FETCH.
//   JUMP:   pcwrite=1, pcsource=10, then FETCH.
//   ADDIEX: alusrca=1, alusrcb=10, aluop=00, then ADDIWB (regwrite=1, regdst=0) -> FETCH.
//   Memory wait: the counter increments each cycle that FETCH, MEMRD or MEMWR sees mem_ready=0.
//     It clears on state exit. When the count reaches MEM_TIMEOUT: pulse bus_err, abort to FETCH,
//     and assert no write enables in that cycle.
//   mem_ready is ignored outside FETCH, MEMRD and MEMWR.
//   Unused encodings 12-15 go to FETCH next cycle with all outputs 0.
//   Asynchronous reset mid-instruction abandons it; no partial regwrite or memwrite occurs after reset.
//   Latency with mem_ready=1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
// TESTING
//   reset high, then low, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; ALUWB has regwrite=1
//     and regdst=1; EXEC has aluop=10.
//   opcode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with
//     memtoreg=1 and regwrite=1.
//   opcode=000100 -> BRANCH with aluop=01, pcwritecond=1, pcsource=01; 3 cycles total.
//   opcode=111111 -> DECODE to FETCH, illegal_op high for exactly 1 cycle, no regwrite or memwrite.
//   MEM_TIMEOUT=4, mem_ready held 0 in MEMWR -> bus_err pulse after 4 wait cycles, then FETCH;
//     memwrite drops.
//   reset asserted mid-MEMWR -> state=0 immediately (asynchronous); memwrite=0 in the same cycle.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state sequencing, datapath selects and
// enables, and memory-ready stalls with a bounded wait that aborts to FETCH with bus_err.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [5:0]    r_opcode;
  logic [CW-1:0] r_wait_cnt;
  logic          r_illegal_op;
  logic          r_bus_err;
  logic          w_wait_state;
  logic          w_timeout;
  logic          w_illegal;
  logic          w_unused;

  // zero qualifies pcwritecond inside the datapath; the sequencing never depends on it.
  assign w_unused = zero;

  assign w_wait_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
  assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_state && (r_wait_cnt == CW'(MEM_TIMEOUT));
  assign w_illegal    = (r_state == DECODE) && (w_next == FETCH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_opcode     <= OP_RTYPE;
      r_wait_cnt   <= '0;
      r_illegal_op <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_illegal_op <= w_illegal;
      r_bus_err    <= w_timeout;
      if (r_state == DECODE) r_opcode <= opcode;
      // The wait count is per-state: any exit or abort restarts it; it saturates when disabled.
      if (w_timeout || (w_next != r_state)) begin
        r_wait_cnt <= '0;
      end else if (w_wait_state && !mem_ready && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = EXEC;
          OP_LW, OP_SW: w_next = MEMADR;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDIEX;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR: w_next = (r_opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) w_next = MEMWB;
      MEMWR:  if (mem_ready) w_next = FETCH;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
    if (w_timeout) w_next = FETCH;
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop       = 2'b00;
    case (r_state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready && !w_timeout;
        pcwrite = mem_ready && !w_timeout;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = !w_timeout;
        iord     = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      default: ;
    endcase
  end

  assign illegal_op = r_illegal_op;
  assign bus_err    = r_bus_err;
  assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control (MEM_TIMEOUT=4): walks each instruction class,
// memory stalls, the wait timeout, an illegal opcode and an asynchronous reset mid-store.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsource, aluop;
  logic       illegal_op, bus_err;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop(aluop), .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk4("reset_state", state, 4'd0);
    chk1("reset_illegal", illegal_op, 1'b0);
    chk1("reset_buserr", bus_err, 1'b0);
    chk1("reset_regwrite", regwrite, 1'b0);
    reset = 1'b0;
    #1;
    chk1("fetch_memread", memread, 1'b1);
    chk1("fetch_irwrite", irwrite, 1'b1);
    chk1("fetch_pcwrite", pcwrite, 1'b1);
    chk2("fetch_alusrcb", alusrcb, 2'b01);

    // R-type: 0,1,6,7,0
    tick(); chk4("r_decode", state, 4'd1); chk2("decode_alusrcb", alusrcb, 2'b11);
    tick(); chk4("r_exec", state, 4'd6); chk2("exec_aluop", aluop, 2'b10);
    chk1("exec_alusrca", alusrca, 1'b1); chk2("exec_alusrcb", alusrcb, 2'b00);
    tick(); chk4("r_aluwb", state, 4'd7);
    chk1("aluwb_regwrite", regwrite, 1'b1); chk1("aluwb_regdst", regdst, 1'b1);
    chk1("aluwb_memtoreg", memtoreg, 1'b0);
    opcode = 6'b100011;
    tick(); chk4("r_fetch", state, 4'd0);

    // lw with three stalled edges in MEMRD
    tick(); chk4("lw_decode", state, 4'd1);
    tick(); chk4("lw_memadr", state, 4'd2); chk2("memadr_alusrcb", alusrcb, 2'b10);
    mem_ready = 1'b0;
    tick(); chk4("lw_memrd1", state, 4'd3);
    chk1("memrd_memread", memread, 1'b1); chk1("memrd_iord", iord, 1'b1);
    tick(); chk4("lw_memrd2", state, 4'd3);
    tick(); chk4("lw_memrd3", state, 4'd3);
    tick(); chk4("lw_memrd4", state, 4'd3); chk1("lw_no_buserr", bus_err, 1'b0);
    mem_ready = 1'b1;
    tick(); chk4("lw_memwb", state, 4'd4);
    chk1("memwb_memtoreg", memtoreg, 1'b1); chk1("memwb_regwrite", regwrite, 1'b1);
    chk1("memwb_regdst", regdst, 1'b0);
    opcode = 6'b000100;
    tick(); chk4("lw_fetch", state, 4'd0);

    // beq: 3 cycles
    tick(); chk4("beq_decode", state, 4'd1);
    tick(); chk4("beq_branch", state, 4'd8);
    chk2("branch_aluop", aluop, 2'b01); chk1("branch_pcwritecond", pcwritecond, 1'b1);
    chk2("branch_pcsource", pcsource, 2'b01); chk1("branch_pcwrite", pcwrite, 1'b0);
    opcode = 6'b111111;
    tick(); chk4("beq_fetch", state, 4'd0);

    // illegal opcode
    tick(); chk4("ill_decode", state, 4'd1); chk1("ill_not_yet", illegal_op, 1'b0);
    tick(); chk4("ill_fetch", state, 4'd0); chk1("ill_pulse", illegal_op, 1'b1);
    chk1("ill_regwrite", regwrite, 1'b0); chk1("ill_memwrite", memwrite, 1'b0);
    opcode = 6'b101011;
    tick(); chk4("sw_decode", state, 4'd1); chk1("ill_one_cycle", illegal_op, 1'b0);

    // sw with memory never ready: 4 wait cycles, abort cycle, then FETCH with bus_err
    tick(); chk4("sw_memadr", state, 4'd2);
    mem_ready = 1'b0;
    tick(); chk4("sw_memwr1", state, 4'd5); chk1("memwr_memwrite", memwrite, 1'b1);
    chk1("memwr_iord", iord, 1'b1);
    tick(); chk1("memwr2_memwrite", memwrite, 1'b1);
    tick(); chk1("memwr3_memwrite", memwrite, 1'b1);
    tick(); chk4("sw_memwr4", state, 4'd5); chk1("memwr4_memwrite", memwrite, 1'b1);
    tick(); chk4("sw_abort", state, 4'd5); chk1("abort_memwrite", memwrite, 1'b0);
    chk1("abort_buserr_pending", bus_err, 1'b0);
    tick(); chk4("to_fetch", state, 4'd0); chk1("buserr_pulse", bus_err, 1'b1);
    chk1("buserr_memwrite", memwrite, 1'b0); chk1("stall_irwrite", irwrite, 1'b0);
    mem_ready = 1'b1;
    tick(); chk4("sw2_decode", state, 4'd1); chk1("buserr_one_cycle", bus_err, 1'b0);

    // asynchronous reset during MEMWR
    tick(); chk4("sw2_memadr", state, 4'd2);
    mem_ready = 1'b0;
    tick(); chk4("sw2_memwr", state, 4'd5); chk1("sw2_memwrite", memwrite, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk4("async_reset_state", state, 4'd0);
    chk1("async_reset_memwrite", memwrite, 1'b0);
    chk1("async_reset_regwrite", regwrite, 1'b0);
    opcode = 6'b000010; mem_ready = 1'b1;
    #3 reset = 1'b0;

    // j: 3 cycles
    tick(); chk4("j_decode", state, 4'd1);
    tick(); chk4("j_jump", state, 4'd9);
    chk1("jump_pcwrite", pcwrite, 1'b1); chk2("jump_pcsource", pcsource, 2'b10);
    opcode = 6'b001000;
    tick(); chk4("j_fetch", state, 4'd0);

    // addi: 4 cycles
    tick(); chk4("addi_decode", state, 4'd1);
    tick(); chk4("addi_ex", state, 4'd10);
    chk1("addiex_alusrca", alusrca, 1'b1); chk2("addiex_alusrcb", alusrcb, 2'b10);
    chk2("addiex_aluop", aluop, 2'b00);
    tick(); chk4("addi_wb", state, 4'd11);
    chk1("addiwb_regwrite", regwrite, 1'b1); chk1("addiwb_regdst", regdst, 1'b0);
    tick(); chk4("addi_fetch", state, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
